ibex_multdiv_seq: RTL

- Parametrised, width-generic sequential multiply/divide unit for the next-generation EX stage.
- Replaces the fixed 32-bit, decoder-driven multdiv path with a self-contained valid/ready unit.
- Computes radix-2 shift-add multiply and restoring divide, one iteration per cycle.
- Owns its accumulator state internally, with no external intermediate-value register, and supports flush and output backpressure.

---
 rtl/ibex_multdiv_seq_pkg.sv | 34 +++
 rtl/ibex_multdiv_seq_step.sv | 35 +++
 rtl/ibex_multdiv_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ibex_multdiv_seq_pkg.sv
// Shared types and operator-classification helpers for the sequential multiply/divide unit.
package ibex_multdiv_seq_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_seq_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } md_seq_state_e;

    function automatic logic is_signed_a(md_seq_op_e op);
        return op inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic is_signed_b(md_seq_op_e op);
        return op inside {MUL, MULH, DIV, REM};
    endfunction

    function automatic logic is_div(md_seq_op_e op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/ibex_multdiv_seq_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on a 2*Width accumulator.
module ibex_multdiv_seq_step #(
    parameter int unsigned Width = 32
) (
    input  logic                 div_mode,
    input  logic [2*Width-1:0]   acc,
    input  logic [Width-1:0]     operand,
    output logic [2*Width-1:0]   acc_next,
    output logic                 q_bit
);

    logic [Width:0]   mul_sum;
    logic [Width:0]   rem_shift;
    logic [Width+1:0] diff;
    logic             no_borrow;

    // Multiply: accumulator is {partial product high, remaining multiplier bits}.
    assign mul_sum   = {1'b0, acc[2*Width-1:Width]} + ({(Width+1){acc[0]}} & {1'b0, operand});

    // Divide: accumulator is {partial remainder, remaining dividend / quotient bits}.
    assign rem_shift = acc[2*Width-1:Width-1];
    assign diff      = {1'b0, rem_shift} - {2'b00, operand};
    assign no_borrow = ~diff[Width+1];

    always_comb begin
        q_bit    = 1'b0;
        acc_next = {mul_sum, acc[Width-1:1]};
        if (div_mode) begin
            q_bit    = no_borrow;
            acc_next = {(no_borrow ? diff[Width-1:0] : rem_shift[Width-1:0]),
                        acc[Width-2:0], no_borrow};
        end
    end

endmodule

// File: rtl/ibex_multdiv_seq.sv
// Sequential multiply/divide unit with valid/ready handshake, flush and output backpressure.
// Optional macro IBEX_MULTDIV_SEQ_EARLY_OUT_EN enables the two-cycle early-out for trivial operands.
module ibex_multdiv_seq
    import ibex_multdiv_seq_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned CntW  = $clog2(Width + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       operator_i,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    input  logic             data_ind_timing_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] result_o,
    output logic             busy_o
);

    localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

    md_seq_state_e      state_reg, state_next;
    logic [CntW-1:0]    counter_reg;
    md_seq_op_e         op_reg;
    logic               sign_reg;
    logic               div_zero_reg;
    logic               div_ovf_reg;
    logic [Width-1:0]   a_orig_reg;
    logic [Width-1:0]   operand_reg;
    logic [2*Width-1:0] acc_reg;
    logic [Width-1:0]   result_reg;

    md_seq_op_e         op_in;
    logic               sign_a, sign_b;
    logic [Width-1:0]   a_mag, b_mag;
    logic               b_zero, ovf_in, sign_in;
    logic               accept, early_out;
    logic [2*Width-1:0] acc_step;
    logic               q_bit;
    logic [2*Width-1:0] prod_signed;
    logic [Width-1:0]   quot, rem;
    logic [Width-1:0]   fix_result;

    assign op_in  = md_seq_op_e'(operator_i);
    assign sign_a = is_signed_a(op_in) & operand_a_i[Width-1];
    assign sign_b = is_signed_b(op_in) & operand_b_i[Width-1];
    assign a_mag  = sign_a ? -operand_a_i : operand_a_i;
    assign b_mag  = sign_b ? -operand_b_i : operand_b_i;
    assign b_zero = (operand_b_i == '0);
    assign ovf_in = is_div(op_in) && is_signed_a(op_in) && (operand_a_i == MinVal) && (&operand_b_i);
    // Remainder takes the dividend's sign; every other result takes the product/quotient sign.
    assign sign_in = (op_in == REM) ? sign_a : (sign_a ^ sign_b);
    assign accept  = in_valid_i && in_ready_o && !flush_i;

`ifdef IBEX_MULTDIV_SEQ_EARLY_OUT_EN
    assign early_out = !data_ind_timing_i &&
                       (is_div(op_in) ? (b_zero || ovf_in) : ((operand_a_i == '0) || b_zero));
`else
    logic unused_data_ind_timing;
    assign unused_data_ind_timing = data_ind_timing_i;
    assign early_out = 1'b0;
`endif

    ibex_multdiv_seq_step #(
        .Width(Width)
    ) u_step (
        .div_mode (is_div(op_reg)),
        .acc      (acc_reg),
        .operand  (operand_reg),
        .acc_next (acc_step),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (in_valid_i) state_next = early_out ? FIXUP : CALC;
            CALC:    if (counter_reg == CntW'(Width - 1)) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    if (out_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        in_ready_o  = (state_reg == IDLE);
        busy_o      = (state_reg != IDLE);
        out_valid_o = (state_reg == DONE);
        result_o    = result_reg;
    end

    assign prod_signed = sign_reg ? -acc_reg : acc_reg;
    assign quot        = acc_reg[Width-1:0];
    assign rem         = acc_reg[2*Width-1:Width];

    always_comb begin
        fix_result = '0;
        unique case (op_reg)
            MUL:                 fix_result = prod_signed[Width-1:0];
            MULH, MULHSU, MULHU: fix_result = prod_signed[2*Width-1:Width];
            DIV, DIVU: begin
                if (div_zero_reg)      fix_result = '1;
                else if (div_ovf_reg)  fix_result = MinVal;
                else                   fix_result = sign_reg ? -quot : quot;
            end
            REM, REMU: begin
                if (div_zero_reg)      fix_result = a_orig_reg;
                else if (div_ovf_reg)  fix_result = '0;
                else                   fix_result = sign_reg ? -rem : rem;
            end
            default:             fix_result = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            counter_reg  <= '0;
            op_reg       <= MUL;
            sign_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            div_ovf_reg  <= 1'b0;
            a_orig_reg   <= '0;
            operand_reg  <= '0;
            acc_reg      <= '0;
            result_reg   <= '0;
        end else if (!flush_i) begin
            if (accept) begin
                counter_reg  <= '0;
                op_reg       <= op_in;
                sign_reg     <= sign_in;
                div_zero_reg <= b_zero;
                div_ovf_reg  <= ovf_in;
                a_orig_reg   <= operand_a_i;
                if (early_out) begin
                    // Zero product; divide overrides ignore the accumulator entirely.
                    acc_reg     <= '0;
                    operand_reg <= '0;
                end else if (is_div(op_in)) begin
                    acc_reg     <= {{Width{1'b0}}, a_mag};
                    operand_reg <= b_mag;
                end else begin
                    acc_reg     <= {{Width{1'b0}}, b_mag};
                    operand_reg <= a_mag;
                end
            end else if (state_reg == CALC) begin
                acc_reg     <= acc_step;
                counter_reg <= counter_reg + CntW'(1);
            end else if (state_reg == FIXUP) begin
                result_reg <= fix_result;
            end
        end
    end

endmodule
